// File: rtl/bg_cal_ctrl.sv
// bg_cal_ctrl: bandgap power-on sequencer followed by coarse then fine chopped SAR calibration.
module bg_cal_ctrl #(
  parameter int STARTUP = 8,
  parameter int SETTLE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmp_o,
  output logic [7:0] ib,
  output logic [7:0] ibf,
  output logic       res_n,
  output logic [7:0] diode,
  output logic [3:0] idac_o,
  output logic [2:0] state,
  output logic [1:0] c1,
  output logic [1:0] c2,
  output logic       coarse,
  output logic       valid
);
  typedef enum logic [2:0] {IDLE = 3'd0, INIT = 3'd1, COARSE = 3'd2, FINE = 3'd3, DONE = 3'd4} state_t;
  localparam logic [15:0] ST_END = 16'(STARTUP - 1);
  localparam logic [15:0] SE_END = 16'(SETTLE - 1);
  state_t      state_q;
  logic [7:0]  ib_q, ibf_q, diode_q, mask, code_d;
  logic [3:0]  idac_q;
  logic [1:0]  c1_q, c2_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic        res_n_q, coarse_q, valid_q, s1_q, s2_q, a_q, ph_q, clr;
  // Trial bit is already set: clear it only on a clean a=0/b=1 chop pair, then arm the next bit.
  always_comb begin
    mask   = 8'd1 << bit_q;
    clr    = !a_q && s2_q;
    code_d = ((state_q == COARSE ? ib_q : ibf_q) & ~(clr ? mask : 8'h00)) | (mask >> 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ib_q     <= 8'h00;
      ibf_q    <= 8'h00;
      res_n_q  <= 1'b1;
      diode_q  <= 8'h00;
      idac_q   <= 4'hF;
      c1_q     <= 2'b00;
      c2_q     <= 2'b00;
      coarse_q <= 1'b0;
      valid_q  <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      a_q      <= 1'b0;
      ph_q     <= 1'b0;
      cnt_q    <= 16'd0;
      bit_q    <= 3'd0;
    end else begin
      s1_q <= cmp_o;
      s2_q <= s1_q;
      case (state_q)
        IDLE: begin
          state_q <= INIT;
          cnt_q   <= 16'd0;
          idac_q  <= 4'hE;
          diode_q <= 8'h01;
          res_n_q <= 1'b1;
        end
        INIT: begin
          cnt_q <= cnt_q + 16'd1;
          if (cnt_q == ST_END) begin
            state_q  <= COARSE;
            ib_q     <= 8'h80;
            bit_q    <= 3'd7;
            cnt_q    <= 16'd0;
            ph_q     <= 1'b0;
            coarse_q <= 1'b1;
            c1_q     <= 2'b01;
            c2_q     <= 2'b10;
          end
        end
        COARSE, FINE: begin
          cnt_q <= cnt_q + 16'd1;
          if (cnt_q == SE_END) begin
            cnt_q <= 16'd0;
            ph_q  <= !ph_q;
            c1_q  <= ph_q ? 2'b01 : 2'b10;
            c2_q  <= ph_q ? 2'b10 : 2'b01;
            if (!ph_q) a_q <= s2_q;
            else begin
              bit_q <= bit_q - 3'd1;
              if (state_q == COARSE) ib_q <= code_d;
              else ibf_q <= code_d;
              if (bit_q == 3'd0 && state_q == COARSE) begin
                state_q  <= FINE;
                ibf_q    <= 8'h80;
                coarse_q <= 1'b0;
                idac_q   <= 4'hD;
                diode_q  <= 8'hFF;
                res_n_q  <= 1'b0;
              end else if (bit_q == 3'd0) begin
                state_q <= DONE;
                valid_q <= 1'b1;
                idac_q  <= 4'hB;
                c1_q    <= 2'b00;
                c2_q    <= 2'b00;
              end
            end
          end
        end
        DONE: state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign state  = state_q;
  assign ib     = ib_q;
  assign ibf    = ibf_q;
  assign res_n  = res_n_q;
  assign diode  = diode_q;
  assign idac_o = idac_q;
  assign c1     = c1_q;
  assign c2     = c2_q;
  assign coarse = coarse_q;
  assign valid  = valid_q;
endmodule

// File: tb/tb_bg_cal_ctrl.sv
// tb_bg_cal_ctrl: table-driven calibration scenarios on a default and a short-timing instance.
module tb_bg_cal_ctrl;
  logic clk = 0, reset = 1, cmp_r = 0, sel = 0;
  int   mode = 0, errors = 0, checks = 0;
  always #5 clk = ~clk;

  logic [7:0] ib_a, ibf_a, diode_a, ib_b, ibf_b, diode_b, ib, ibf, diode;
  logic [3:0] idac_a, idac_b, idac;
  logic [2:0] state_a, state_b, state;
  logic [1:0] c1_a, c2_a, c1_b, c2_b, c1, c2;
  logic       res_n_a, res_n_b, res_n, coarse_a, coarse_b, coarse, valid_a, valid_b, valid, cmp;

  bg_cal_ctrl u_a (.clk(clk), .reset(reset), .cmp_o(cmp), .ib(ib_a), .ibf(ibf_a), .res_n(res_n_a),
    .diode(diode_a), .idac_o(idac_a), .state(state_a), .c1(c1_a), .c2(c2_a), .coarse(coarse_a), .valid(valid_a));
  bg_cal_ctrl #(.STARTUP(2), .SETTLE(3)) u_b (.clk(clk), .reset(reset), .cmp_o(cmp), .ib(ib_b), .ibf(ibf_b),
    .res_n(res_n_b), .diode(diode_b), .idac_o(idac_b), .state(state_b), .c1(c1_b), .c2(c2_b),
    .coarse(coarse_b), .valid(valid_b));

  assign ib     = sel ? ib_b : ib_a;
  assign ibf    = sel ? ibf_b : ibf_a;
  assign diode  = sel ? diode_b : diode_a;
  assign idac   = sel ? idac_b : idac_a;
  assign state  = sel ? state_b : state_a;
  assign c1     = sel ? c1_b : c1_a;
  assign c2     = sel ? c2_b : c2_a;
  assign res_n  = sel ? res_n_b : res_n_a;
  assign coarse = sel ? coarse_b : coarse_a;
  assign valid  = sel ? valid_b : valid_a;
  // mode 2: a=0/b=1 every trial; mode 4: a=1/b=0 every trial; otherwise scripted level
  assign cmp = mode == 2 ? c1[1] : mode == 4 ? ~c1[1] : cmp_r;

  typedef struct {
    bit         sel;
    int         mode;
    logic [7:0] tib;
    logic [7:0] tibf;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, {26'd0, state, ib, ibf, res_n, diode, idac, c1, c2, coarse, valid},
        {26'd0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0});
  endtask

  task automatic run(input vec_t v, input int abort);
    int st, se, done, n, k, tr;
    logic bv;
    st = v.sel ? 2 : 8;
    se = v.sel ? 3 : 4;
    done = 1 + st + 32 * se;
    sel = v.sel;
    mode = v.mode;
    cmp_r = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    reset = 0;
    n = 0;
    while (n < done + 2) begin
      @(posedge clk);
      #1 n++;
      if (n == 1) chk("idle_to_init", 64'(state), 64'd1);
      if (n == st) chk("init_last", 64'({state, coarse}), 64'({3'd1, 1'b0}));
      if (n == 1 + st)
        chk("coarse_entry", 64'({state, coarse, ib, c1, c2, idac, diode, res_n}),
            64'({3'd2, 1'b1, 8'h80, 2'b01, 2'b10, 4'hE, 8'h01, 1'b1}));
      if (n == 1 + st + se) chk("phase_b", 64'({c1, c2}), 64'({2'b10, 2'b01}));
      if (n == 1 + st + se - 1) chk("phase_a_last", 64'({c1, c2}), 64'({2'b01, 2'b10}));
      for (int j = 1; j < 8; j++) begin
        if (n == 1 + st + 2 * se * j)
          chk($sformatf("ib_step%0d", j), 64'({state, ib}), 64'({3'd2, (v.tib & ~(8'hFF >> j)) | (8'h80 >> j)}));
        if (n == 1 + st + 16 * se + 2 * se * j)
          chk($sformatf("ibf_step%0d", j), 64'({state, ib, ibf}),
              64'({3'd3, v.tib, (v.tibf & ~(8'hFF >> j)) | (8'h80 >> j)}));
      end
      if (n == st + 16 * se) chk("coarse_last", 64'({state, coarse}), 64'({3'd2, 1'b1}));
      if (n == 1 + st + 16 * se)
        chk("fine_entry", 64'({state, coarse, ib, ibf, idac, diode, res_n}),
            64'({3'd3, 1'b0, v.tib, 8'h80, 4'hD, 8'hFF, 1'b0}));
      if (n == done - 1) chk("pre_done", 64'({state, valid}), 64'({3'd3, 1'b0}));
      if (n == done || n == done + 2)
        chk("done", 64'({state, valid, ib, ibf, c1, c2, idac, diode, res_n, coarse}),
            64'({3'd4, 1'b1, v.tib, v.tibf, 2'b00, 2'b00, 4'hB, 8'hFF, 1'b0, 1'b0}));
      if (n == abort) begin
        reset = 1;
        @(posedge clk);
        #1 chk_reset("mid_reset");
        reset = 0;
        n = 0;
        abort = 0;
      end
      cmp_r = 0;
      k = n - (1 + st);
      if (mode == 1) cmp_r = 1;
      if (mode == 3 && k >= 0 && k < 32 * se) begin
        tr = k / (2 * se);
        bv = tr < 8 ? v.tib[7 - tr] : v.tibf[15 - tr];
        cmp_r = !bv && (k % (2 * se)) >= se;
      end
    end
  endtask

  initial begin
    vt[0] = '{1'b0, 0, 8'hFF, 8'hFF};
    vt[1] = '{1'b0, 1, 8'hFF, 8'hFF};
    vt[2] = '{1'b0, 2, 8'h00, 8'h00};
    vt[3] = '{1'b0, 3, 8'h5A, 8'hC3};
    vt[4] = '{1'b0, 4, 8'hFF, 8'hFF};
    vt[5] = '{1'b1, 0, 8'hFF, 8'hFF};
    vt[6] = '{1'b1, 3, 8'h5A, 8'hC3};
    for (int i = 0; i < 7; i++) run(vt[i], -1);
    run('{1'b0, 3, 8'hA5, 8'h3C}, -1);
    run('{1'b0, 0, 8'hFF, 8'hFF}, 100);
    run('{1'b1, 2, 8'h00, 8'h00}, 50);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
